// File: rtl/rf_checkpoint_ctrl.sv
// Checkpoint/restore slots for a register file dump port. Restore drives dump_wr_en_o one cycle, two edges after the call;
// save/restore are refused via save_rdy/restore_rdy when full or busy. Optional stats counters: RF_CKPT_STATS_EN.
module rf_checkpoint_ctrl #(
  parameter int DTYPE  = 8,
  parameter int NREGS  = 2,
  parameter int NSLOTS = 4,
  localparam int IW = $clog2(NSLOTS),
  localparam int DW = DTYPE * NREGS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] dump_out_i,
  output logic [DW-1:0] dump_in_o,
  output logic          dump_wr_en_o,
  input  logic          save_call,
  output logic          save_rdy,
  output logic [IW-1:0] save_id,
  input  logic          restore_call,
  input  logic [IW-1:0] restore_id,
  output logic          restore_rdy,
  input  logic          free_call,
  input  logic [IW-1:0] free_id,
  output logic          restore_err,
  output logic [IW:0]   occupancy
`ifdef RF_CKPT_STATS_EN
  ,
  output logic [15:0]   stat_saves,
  output logic [15:0]   stat_restores,
  output logic [15:0]   stat_errs
`endif
);

  typedef enum logic {IDLE, RESTORE} state_t;

  state_t              state, state_nxt;
  logic [DW-1:0]       slot_mem [NSLOTS];
  logic [NSLOTS-1:0]   valid, valid_nxt;
  logic                any_free;
  logic                save_fire;
  logic                restore_hit;
  logic                restore_miss;
  logic [IW:0]         occ_nxt;

  // Lowest-index free slot wins allocation.
  always_comb begin
    save_id  = '0;
    any_free = 1'b0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        save_id  = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign save_rdy     = (state == IDLE) && any_free;
  assign save_fire    = save_call && save_rdy;
  assign restore_hit  = restore_call && (state == IDLE) && valid[restore_id];
  assign restore_miss = restore_call && (state == IDLE) && !valid[restore_id];

  always_comb begin
    state_nxt    = state;
    restore_rdy  = 1'b0;
    dump_wr_en_o = 1'b0;
    case (state)
      IDLE: begin
        restore_rdy = 1'b1;
        if (restore_hit) state_nxt = RESTORE;
      end
      RESTORE: begin
        dump_wr_en_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Free only clears a slot that was already valid, so it can never cancel a same-cycle save.
  always_comb begin
    valid_nxt = valid;
    if (save_fire) valid_nxt[save_id] = 1'b1;
    if (restore_hit) valid_nxt[restore_id] = 1'b0;
    if (free_call && valid[free_id]) valid_nxt[free_id] = 1'b0;
    occ_nxt = '0;
    for (int i = 0; i < NSLOTS; i++) occ_nxt = occ_nxt + (IW+1)'(valid_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      valid       <= '0;
      occupancy   <= '0;
      dump_in_o   <= '0;
      restore_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      valid       <= valid_nxt;
      occupancy   <= occ_nxt;
      restore_err <= restore_miss;
      if (restore_hit) dump_in_o <= slot_mem[restore_id];
    end
  end

  always_ff @(posedge clk) begin
    if (save_fire) slot_mem[save_id] <= dump_out_i;
  end

`ifdef RF_CKPT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_saves    <= '0;
      stat_restores <= '0;
      stat_errs     <= '0;
    end else begin
      if (save_fire && stat_saves != 16'hFFFF) stat_saves <= stat_saves + 16'd1;
      if (restore_hit && stat_restores != 16'hFFFF) stat_restores <= stat_restores + 16'd1;
      if (restore_miss && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_checkpoint_ctrl.sv
// Directed + random bench for rf_checkpoint_ctrl against a slot-list reference model.
module tb_rf_checkpoint_ctrl;
  localparam int NSLOTS = 4;

  logic        clk;
  logic        reset;
  logic [15:0] dump_out_i;
  logic [15:0] dump_in_o;
  logic        dump_wr_en_o;
  logic        save_call;
  logic        save_rdy;
  logic [1:0]  save_id;
  logic        restore_call;
  logic [1:0]  restore_id;
  logic        restore_rdy;
  logic        free_call;
  logic [1:0]  free_id;
  logic        restore_err;
  logic [2:0]  occupancy;
`ifdef RF_CKPT_STATS_EN
  logic [15:0] stat_saves, stat_restores, stat_errs;
`endif

  rf_checkpoint_ctrl #(.DTYPE(8), .NREGS(2), .NSLOTS(NSLOTS)) dut (
    .clk(clk), .reset(reset),
    .dump_out_i(dump_out_i), .dump_in_o(dump_in_o), .dump_wr_en_o(dump_wr_en_o),
    .save_call(save_call), .save_rdy(save_rdy), .save_id(save_id),
    .restore_call(restore_call), .restore_id(restore_id), .restore_rdy(restore_rdy),
    .free_call(free_call), .free_id(free_id),
    .restore_err(restore_err), .occupancy(occupancy)
`ifdef RF_CKPT_STATS_EN
    , .stat_saves(stat_saves), .stat_restores(stat_restores), .stat_errs(stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: which slots hold a snapshot, what they hold, and pending outputs.
  bit          m_valid [NSLOTS];
  logic [15:0] m_data  [NSLOTS];
  bit          m_in_restore;
  logic [15:0] m_din;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < NSLOTS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < NSLOTS; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSLOTS; i++) m_valid[i] = 1'b0;
    m_in_restore = 1'b0;
    m_din        = 16'h0;
    m_err        = 1'b0;
  endtask

  // One cycle: drive inputs, check outputs against the model, clock, advance the model.
  task automatic step(input bit sc, input logic [15:0] d, input bit rc, input logic [1:0] rid,
                      input bit fc, input logic [1:0] fid);
    int  ff;
    bit  can_save, do_restore, hit;
    bit  old_valid [NSLOTS];
    save_call = sc; dump_out_i = d; restore_call = rc; restore_id = rid;
    free_call = fc; free_id = fid;
    #1;
    ff       = first_free();
    can_save = !m_in_restore && (ff >= 0);
    chk("save_rdy", 32'(save_rdy), 32'(can_save));
    if (can_save) chk("save_id", 32'(save_id), 32'(ff));
    chk("restore_rdy", 32'(restore_rdy), 32'(!m_in_restore));
    chk("dump_wr_en", 32'(dump_wr_en_o), 32'(m_in_restore));
    chk("dump_in", 32'(dump_in_o), 32'(m_din));
    chk("restore_err", 32'(restore_err), 32'(m_err));
    chk("occupancy", 32'(occupancy), 32'(count_valid()));
    @(posedge clk);
    for (int i = 0; i < NSLOTS; i++) old_valid[i] = m_valid[i];
    do_restore = rc && !m_in_restore;
    hit        = do_restore && old_valid[rid];
    m_err      = do_restore && !old_valid[rid];
    if (hit) m_din = m_data[rid];
    m_in_restore = hit;
    if (sc && can_save) begin
      m_valid[ff] = 1'b1;
      m_data[ff]  = d;
    end
    if (hit) m_valid[rid] = 1'b0;
    if (fc && old_valid[fid]) m_valid[fid] = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 2'd0, 0, 2'd0);
  endtask

  initial begin
    reset = 1'b0;
    save_call = 0; restore_call = 0; free_call = 0;
    dump_out_i = 16'h0; restore_id = 2'd0; free_id = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state and idle.
    idle(1);

    // Save A55A, change input, restore slot 0.
    step(1, 16'hA55A, 0, 2'd0, 0, 2'd0);
    step(0, 16'h0000, 0, 2'd0, 0, 2'd0);
    step(0, 16'h0000, 1, 2'd0, 0, 2'd0);
    chk("restore_busy_wr", 32'(dump_wr_en_o), 32'h1);
    chk("restore_busy_dat", 32'(dump_in_o), 32'hA55A);
    idle(2);

    // Fill all four slots, then free slot 2 and reallocate it.
    step(1, 16'h0101, 0, 2'd0, 0, 2'd0);
    step(1, 16'h0202, 0, 2'd0, 0, 2'd0);
    step(1, 16'h0303, 0, 2'd0, 0, 2'd0);
    step(1, 16'h0404, 0, 2'd0, 0, 2'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    step(1, 16'hDEAD, 0, 2'd0, 1, 2'd2);
    step(0, 16'h0, 0, 2'd0, 0, 2'd0);
    chk("realloc_id", 32'(save_id), 32'd2);

    // Free 2 and 3, then restore invalid slot 3.
    step(0, 16'h0, 0, 2'd0, 1, 2'd3);
    step(0, 16'h0, 1, 2'd3, 0, 2'd0);
    chk("err_pulse", 32'(restore_err), 32'h1);
    idle(2);

    // Same-cycle save and restore of slot 1 (slots 0,1 valid).
    step(1, 16'hBEEF, 1, 2'd1, 0, 2'd0);
    chk("sr_dat", 32'(dump_in_o), 32'h0202);
    chk("sr_occ", 32'(occupancy), 32'd2);
    idle(2);

    // Restore + free of the same slot; then save+free collision.
    step(0, 16'h0, 1, 2'd0, 1, 2'd0);
    idle(1);
    step(1, 16'h1234, 0, 2'd0, 1, 2'd2);
    idle(2);

    // Reset asserted in the middle of a RESTORE cycle.
    step(1, 16'h5A5A, 0, 2'd0, 0, 2'd0);
    step(0, 16'h0, 1, 2'd0, 0, 2'd0);
    chk("pre_abort_wr", 32'(dump_wr_en_o), 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_wr", 32'(dump_wr_en_o), 32'h0);
    chk("abort_occ", 32'(occupancy), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    chk("post_rst_id", 32'(save_id), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 55), 16'($urandom),
           ($urandom_range(0, 99) < 30), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 25), 2'($urandom_range(0, 3)));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rf_checkpoint_ctrl.md
Name: rf_checkpoint_ctrl

Overview:
Checkpoint/restore controller on the far side of a register file's dump interface. It consumes the register file's dump outputs, stores snapshots in an internal slot array, and later drives the register file's dump inputs and dump write enable to restore a chosen snapshot. Rename and speculation logic use it to save architectural state before a branch and roll it back on mispredict.

Parameters:
DTYPE, 8, bit width of one register
NREGS, 2, number of registers in the attached register file
NSLOTS, 4, number of checkpoint slots (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
dump_out_i  in  NREGS*DTYPE  register file dump outputs; reg k at bits [k*DTYPE +: DTYPE]
dump_in_o  out  NREGS*DTYPE  snapshot driven to the register file dump inputs; same packing
dump_wr_en_o  out  1  register file dump write enable
save_call  in  1  request a snapshot of dump_out_i
save_rdy  out  1  a free slot exists and the block is in IDLE
save_id  out  clog2(NSLOTS)  slot allocated to a save issued this cycle
restore_call  in  1  request a restore from restore_id
restore_id  in  clog2(NSLOTS)  slot to restore
restore_rdy  out  1  the block is in IDLE
free_call  in  1  release slot free_id without restoring it
free_id  in  clog2(NSLOTS)  slot to release
restore_err  out  1  one-cycle pulse when a restore targets an invalid slot
occupancy  out  clog2(NSLOTS)+1  number of valid slots

Behaviour:
- State: slot data array, valid[NSLOTS], FSM {IDLE, RESTORE}, registered restore data.
- Reset (reset==0, asynchronous): valid cleared, FSM=IDLE, dump_wr_en_o=0, dump_in_o=0, restore_err=0, occupancy=0. Slot data contents are don't-care.
- save_rdy = IDLE && any(!valid). save_id = lowest-index invalid slot; it is combinational and valid whenever save_rdy=1.
- Save fires when save_call && save_rdy. dump_out_i is captured into slot save_id on that edge and valid is set. A caller must not assert save_call while save_rdy=0; such a request is ignored.
- restore_rdy = (FSM==IDLE). Restore fires when restore_call && restore_rdy.
  - Valid restore_id: the slot data is latched, that slot's valid is cleared, and FSM goes to RESTORE.
  - Invalid restore_id: no state change; restore_err pulses high in the next cycle.
- RESTORE lasts exactly one cycle: dump_wr_en_o=1 and dump_in_o=latched data, then FSM returns to IDLE. The register file therefore loads the snapshot on the edge that ends RESTORE, two edges after the restore call.
- dump_wr_en_o=0 in IDLE. dump_in_o holds its last value outside RESTORE.
- free_call clears valid[free_id] at the next edge. Freeing an invalid slot is a no-op. Free is accepted in either FSM state.
- Simultaneous events in one cycle:
  - save + restore: both fire. The save captures the pre-restore dump_out_i. The save's slot is chosen from the valid bits before this edge, so it cannot equal restore_id.
  - save + free: a slot freed this cycle is not allocatable until the next cycle.
  - restore + free of the same slot: the restore proceeds and the slot ends invalid.
- occupancy is the registered popcount of valid and updates on the same edge as the save, restore or free that changes it.
- Reset asserted during RESTORE aborts it: dump_wr_en_o drops to 0 immediately (asynchronously).

Optional Feature:
Macro RF_CKPT_STATS_EN.
- Defined: adds outputs stat_saves[15:0], stat_restores[15:0] and stat_errs[15:0]. Each is a saturating counter of fired saves, fired valid restores and restore errors. All reset to 0 and saturate at 16'hFFFF.
- Undefined: these ports and their logic are absent. Port list and behaviour are otherwise identical.

Test Plan (all with DTYPE=8, NREGS=2, NSLOTS=4):
- Reset then idle -> save_rdy=1, save_id=0, occupancy=0, dump_wr_en_o=0, restore_rdy=1.
- Save with dump_out_i=16'hA55A, then change dump_out_i to 16'h0000, then restore id 0 -> exactly one cycle of dump_wr_en_o=1 with dump_in_o=16'hA55A, two cycles after the call; occupancy goes 0->1->0.
- Four saves of 16'h0101, 16'h0202, 16'h0303, 16'h0404 -> save_ids 0,1,2,3; save_rdy=0 and occupancy=4 after the fourth. free_id=2 -> next save_id=2.
- Restore id 3 while slot 3 is invalid -> restore_err pulses once, dump_wr_en_o stays 0, occupancy unchanged.
- Same-cycle save (slots 0,1 valid) and restore id 1 -> save gets id 2; the restore drives the slot-1 data; occupancy stays 2.
- reset driven low during the RESTORE cycle -> dump_wr_en_o falls without waiting for a clock edge; after release, occupancy=0 and save_id=0.
